// File: rtl/if_pkg.sv
// Shared fetch/decode definitions: FSM state encoding, default widths,
// opcode field position and the fetch buffer entry layout.
// No logic; imported by the fetch stage and by decode.
package if_pkg;

  localparam int IF_PC_W    = 16;
  localparam int IF_INSTR_W = 32;

  // Opcode field of an instruction word; decode slices the same bits.
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [IF_INSTR_W-1:0] instr;
    logic [IF_PC_W-1:0]    pc;
  } if_entry_t;

endpackage

// File: rtl/if_fetch_buf.sv
// Purpose : DEPTH-entry synchronous FIFO with flush and a registered head entry.
// Latency : a push into an empty FIFO is visible on head_* the next cycle.
// Backpr. : the producer must not push when full; flush wins over push, a pop
//           in the flush cycle still completes.
// Ports   : flush/push/push_dat/pop in; count, head_vld, head_dat out.
module if_fetch_buf #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 48
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_dat,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_vld,
  output logic [DATA_W-1:0]        head_dat
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              wr_en, rd_en;

  assign wr_en = push && !flush;
  assign rd_en = pop && (cnt_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    head_d   = head_q;

    if (wr_en) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(wr_en) - CNT_W'(rd_en);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end

    // The head register only moves when the head entry changes; mem_d already
    // holds this cycle's write, so a push into an empty FIFO lands directly.
    // When the FIFO goes empty the head keeps its last value.
    if ((cnt_d != '0) && (rd_en || (cnt_q == '0))) begin
      head_d = mem_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end

  assign count    = cnt_q;
  assign head_vld = (cnt_q != '0);
  assign head_dat = head_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Purpose : instruction fetch; owns the PC, issues single outstanding imem reads,
//           buffers {instr, pc} and hands them to decode; redirect flushes.
// Latency : gnt in cycle N -> rvalid in N+1 -> id_valid in N+2.
// Backpr. : id_ready low fills the BUF_DEPTH buffer, then imem_req drops.
// Ports   : imem_req/addr/gnt/rvalid/rdata to memory, redirect_valid/pc from
//           execute, id_valid/instr/pc/ready to decode.
// Option  : IF_PERF_CNT_EN adds saturating perf_fetch_cnt / perf_stall_cnt.
import if_pkg::*;

module if_fetch_stage #(
  parameter int              PC_W      = IF_PC_W,
  parameter int              INSTR_W   = IF_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_stall_cnt,
`endif
  input  logic               id_ready
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int ENT_W = INSTR_W + PC_W;

  if_state_e         state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   out_pc_q, out_pc_d;
  logic [CNT_W-1:0]  buf_count;
  logic              buf_vld;
  logic [ENT_W-1:0]  buf_head;
  logic              issue, push, pop;

  // No request while a redirect is pending: the next fetch must be the target.
  // rst_n is folded in so the request is low during reset.
  assign imem_req  = rst_n && (state_q == S_REQ) && (buf_count < CNT_W'(BUF_DEPTH))
                     && !redirect_valid;
  assign imem_addr = pc_q;
  assign issue     = imem_req && imem_gnt;
  // A response landing in the redirect cycle belongs to the old path.
  assign push      = (state_q == S_WAIT) && imem_rvalid && !redirect_valid;
  assign pop       = buf_vld && id_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    out_pc_d = out_pc_q;

    unique case (state_q)
      S_REQ: begin
        if (issue) begin
          out_pc_d = pc_q;
          pc_d     = pc_q + PC_W'(1);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid)         state_d = S_REQ;
        else if (redirect_valid) state_d = S_DROP;
      end
      S_DROP: begin
        // The discarded response retires the outstanding request, even when a
        // second redirect arrives in the same cycle; otherwise we would wait
        // forever for a response that has already come back.
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    if (redirect_valid) begin
      pc_d = redirect_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      out_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      out_pc_q <= out_pc_d;
    end
  end

  if_fetch_buf #(
    .DEPTH  (BUF_DEPTH),
    .DATA_W (ENT_W)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (push),
    .push_dat ({imem_rdata, out_pc_q}),
    .pop      (pop),
    .count    (buf_count),
    .head_vld (buf_vld),
    .head_dat (buf_head)
  );

  assign id_valid = buf_vld;
  assign id_instr = buf_head[ENT_W-1:PC_W];
  assign id_pc    = buf_head[PC_W-1:0];

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (pop && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (buf_vld && !id_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
